acq_search_ctrl: RTL and testbench

ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

---
 rtl/acq_search_if.sv | 46 ++++
 rtl/acq_search_ctrl.sv | 156 +++++++++++++++
 tb/tb_acq_search_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_search_if.sv
// Acquisition search bus: run control, configuration, front-end and
// accumulator strobes from the host side, plus the accumulator controls and
// search results returned by the controller.
// Handshake: start, samp_vld and corr_vld are single-cycle strobes. Each one
// is consumed on the rising edge where it is high, provided the controller is
// in the state that accepts it (IDLE for start, DWELL for samp_vld, WAIT for
// corr_vld). In any other state the strobe is dropped. There is no
// backpressure, so ready is implicit in the controller state.
interface acq_search_if #(
    parameter int CORR_WIDTH    = 32,
    parameter int PRN_PHS_WIDTH = 12,
    parameter int DWELL_WIDTH   = 16
);
    logic                     start;
    logic                     abort;
    logic [PRN_PHS_WIDTH-1:0] phs_max;
    logic [DWELL_WIDTH-1:0]   dwell_len;
    logic [CORR_WIDTH-1:0]    threshold;
    logic                     samp_vld;
    logic                     corr_vld;
    logic [CORR_WIDTH-1:0]    corr_val;
    logic                     acc_clr;
    logic                     acc_en;
    logic [PRN_PHS_WIDTH-1:0] prn_phs;
    logic                     busy;
    logic                     done;
    logic                     acq_ok;
    logic [PRN_PHS_WIDTH-1:0] acq_prn_phs;
    logic [CORR_WIDTH-1:0]    corr_peak;

    // Host / front-end side
    modport master (
        output start, abort, phs_max, dwell_len, threshold,
               samp_vld, corr_vld, corr_val,
        input  acc_clr, acc_en, prn_phs, busy, done, acq_ok,
               acq_prn_phs, corr_peak
    );

    // Search controller side
    modport slave (
        input  start, abort, phs_max, dwell_len, threshold,
               samp_vld, corr_vld, corr_val,
        output acc_clr, acc_en, prn_phs, busy, done, acq_ok,
               acq_prn_phs, corr_peak
    );
endinterface

// File: rtl/acq_search_ctrl.sv
// PRN code-phase search controller. The controller sweeps phases 0..phs_max.
// For each phase it clears the correlator, dwells for dwell_len samples, waits
// for the accumulator result and keeps the strongest peak.
// Optional build macro ACQ_EARLY_EXIT_EN: when defined, the search stops at the
// first phase whose magnitude reaches the threshold.
module acq_search_ctrl #(
    parameter int CORR_WIDTH    = 32,
    parameter int PRN_PHS_WIDTH = 12,
    parameter int DWELL_WIDTH   = 16
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    acq_search_if.slave bus,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_DWELL = 3'd2,
        S_WAIT  = 3'd3,
        S_EVAL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Configuration captured at start so mid-search changes are not seen
    logic [PRN_PHS_WIDTH-1:0] phs_max_r;
    logic [DWELL_WIDTH-1:0]   dwell_len_r;
    logic [CORR_WIDTH-1:0]    threshold_r;

    logic [DWELL_WIDTH-1:0]   dwell_cnt;
    logic [CORR_WIDTH-1:0]    cap_val;
    logic [PRN_PHS_WIDTH-1:0] prn_phs_r;
    logic [PRN_PHS_WIDTH-1:0] acq_prn_phs_r;
    logic [CORR_WIDTH-1:0]    corr_peak_r;
    logic                     acq_ok_r;

    logic                     start_ok;
    logic [DWELL_WIDTH-1:0]   dwell_last;
    logic                     dwell_end;
    logic                     peak_upd;
    logic [CORR_WIDTH-1:0]    peak_new;
    logic                     last_phs;
    logic                     early_hit;
    logic                     eval_finish;

    // A start that arrives together with abort is dropped
    assign start_ok   = bus.start && !bus.abort;
    // A dwell length of zero behaves as a single-sample dwell
    assign dwell_last = (dwell_len_r == '0) ? '0 : dwell_len_r - DWELL_WIDTH'(1);
    assign dwell_end  = bus.samp_vld && (dwell_cnt == dwell_last);
    // Strictly greater, so a tie keeps the earlier phase
    assign peak_upd   = cap_val > corr_peak_r;
    assign peak_new   = peak_upd ? cap_val : corr_peak_r;
    assign last_phs   = prn_phs_r == phs_max_r;
`ifdef ACQ_EARLY_EXIT_EN
    assign early_hit  = cap_val >= threshold_r;
`else
    assign early_hit  = 1'b0;
`endif
    assign eval_finish = last_phs || early_hit;

    // State register
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_DWELL;
            S_DWELL: if (dwell_end) state_nxt = S_WAIT;
            S_WAIT:  if (bus.corr_vld) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = eval_finish ? S_DONE : S_CLEAR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Search datapath: configuration latch, dwell count, capture and peak tracking
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            phs_max_r     <= '0;
            dwell_len_r   <= '0;
            threshold_r   <= '0;
            dwell_cnt     <= '0;
            cap_val       <= '0;
            prn_phs_r     <= '0;
            acq_prn_phs_r <= '0;
            corr_peak_r   <= '0;
            acq_ok_r      <= 1'b0;
        end else if (bus.abort && state != S_IDLE) begin
            acq_ok_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        phs_max_r     <= bus.phs_max;
                        dwell_len_r   <= bus.dwell_len;
                        threshold_r   <= bus.threshold;
                        prn_phs_r     <= '0;
                        acq_prn_phs_r <= '0;
                        corr_peak_r   <= '0;
                        acq_ok_r      <= 1'b0;
                    end
                end
                S_CLEAR: dwell_cnt <= '0;
                S_DWELL: begin
                    if (bus.samp_vld && !dwell_end) begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.corr_vld) begin
                        cap_val <= bus.corr_val;
                    end
                end
                S_EVAL: begin
                    if (peak_upd) begin
                        corr_peak_r   <= cap_val;
                        acq_prn_phs_r <= prn_phs_r;
                    end
                    if (eval_finish) begin
                        acq_ok_r <= peak_new >= threshold_r;
                    end else begin
                        prn_phs_r <= prn_phs_r + PRN_PHS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.acc_clr     = state == S_CLEAR;
    assign bus.acc_en      = (state == S_DWELL) && bus.samp_vld;
    assign bus.busy        = state != S_IDLE;
    // An abort arriving in DONE cancels the completion pulse
    assign bus.done        = (state == S_DONE) && !bus.abort;
    assign bus.acq_ok      = acq_ok_r;
    assign bus.prn_phs     = prn_phs_r;
    assign bus.acq_prn_phs = acq_prn_phs_r;
    assign bus.corr_peak   = corr_peak_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed bench for acq_search_ctrl. The default expectations assume the
// ACQ_EARLY_EXIT_EN macro is undefined; the alternatives are used when it is defined.
module tb_acq_search_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DWELL = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    acq_search_if bus ();

    acq_search_ctrl dut (
        .rx_clk    (clk),
        .rx_rst    (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    int clr_cnt  = 0;
    int en_cnt   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    int          samp_mode = 0;
    int          resp_idx  = 0;
    logic [31:0] tab [8];

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor: tallies strobes once per cycle
    initial begin
        forever begin
            @(negedge clk);
            clr_cnt  += int'(bus.acc_clr);
            en_cnt   += int'(bus.acc_en);
            done_cnt += int'(bus.done);
            busy_cnt += int'(bus.busy);
        end
    end

    // Sample strobe driver: 0 = off, 1 = every cycle, 2 = every third cycle
    initial begin
        int cyc;
        cyc = 0;
        bus.samp_vld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (samp_mode)
                1:       bus.samp_vld = 1'b1;
                2:       bus.samp_vld = (cyc % 3) == 2;
                default: bus.samp_vld = 1'b0;
            endcase
            cyc++;
        end
    end

    // Accumulator model: returns tab[n] two cycles after WAIT entry
    initial begin
        int wcnt;
        wcnt = 0;
        bus.corr_vld = 1'b0;
        bus.corr_val = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.corr_vld = 1'b0;
            if (dbg_state == ST_WAIT) begin
                wcnt++;
                if (wcnt == 2) begin
                    bus.corr_vld = 1'b1;
                    bus.corr_val = tab[resp_idx % 8];
                    resp_idx++;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int phs, input int dwell, input int thr, input int mode);
        @(posedge clk);
        #1;
        bus.phs_max   = 12'(phs);
        bus.dwell_len = 16'(dwell);
        bus.threshold = 32'(thr);
        samp_mode     = mode;
        resp_idx      = 0;
        clr_cnt       = 0;
        en_cnt        = 0;
        done_cnt      = 0;
        busy_cnt      = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input int clr_target, input logic [2:0] st);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (clr_cnt == clr_target && dbg_state == st) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
    endtask

    // directed sequence
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.phs_max = '0;
        bus.dwell_len = '0;
        bus.threshold = '0;
        for (int i = 0; i < 8; i++) tab[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_busy", bus.busy, 0);
        check("rst_outs", {bus.acc_clr, bus.acc_en, bus.done, bus.acq_ok}, 0);
        check("rst_regs", {bus.prn_phs, bus.acq_prn_phs, bus.corr_peak}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // four-phase sweep, threshold met; config changes after start are ignored
        tab[0] = 10; tab[1] = 50; tab[2] = 50; tab[3] = 20;
        setup(3, 4, 40, 1);
        pulse_start();
        bus.phs_max = 12'd0;
        bus.dwell_len = 16'd1;
        bus.threshold = 32'd0;
        wait_done("sweep_done_to", 200);
        check("sweep_done_cnt", done_cnt, 1);
`ifdef ACQ_EARLY_EXIT_EN
        check("sweep_clr_cnt", clr_cnt, 2);
        check("sweep_en_cnt", en_cnt, 8);
        check("sweep_busy_cyc", busy_cnt, 17);
`else
        check("sweep_clr_cnt", clr_cnt, 4);
        check("sweep_en_cnt", en_cnt, 16);
        check("sweep_busy_cyc", busy_cnt, 33);
`endif
        check("sweep_phs", bus.acq_prn_phs, 1);
        check("sweep_peak", bus.corr_peak, 50);
        check("sweep_ok", bus.acq_ok, 1);
        check("sweep_idle", bus.busy, 0);

        // same sweep, threshold above the peak
        setup(3, 4, 60, 1);
        pulse_start();
        wait_done("hi_thr_done_to", 200);
        check("hi_thr_clr_cnt", clr_cnt, 4);
        check("hi_thr_en_cnt", en_cnt, 16);
        check("hi_thr_ok", bus.acq_ok, 0);
        check("hi_thr_peak", bus.corr_peak, 50);
        check("hi_thr_phs", bus.acq_prn_phs, 1);

        // sparse samples: three strobes spaced three cycles apart
        tab[0] = 7;
        setup(0, 3, 5, 2);
        pulse_start();
        wait_done("sparse_done_to", 200);
        check("sparse_en_cnt", en_cnt, 3);
        check("sparse_clr_cnt", clr_cnt, 1);
        check("sparse_peak", bus.corr_peak, 7);
        check("sparse_ok", bus.acq_ok, 1);

        // zero dwell length behaves as one sample
        tab[0] = 3; tab[1] = 9;
        setup(1, 0, 9, 1);
        pulse_start();
        wait_done("dw0_done_to", 200);
        check("dw0_en_cnt", en_cnt, 2);
        check("dw0_busy_cyc", busy_cnt, 11);
        check("dw0_phs", bus.acq_prn_phs, 1);
        check("dw0_ok", bus.acq_ok, 1);

        // large hit at phase 1
        tab[0] = 5; tab[1] = 100; tab[2] = 5; tab[3] = 5;
        setup(3, 2, 40, 1);
        pulse_start();
        wait_done("hit_done_to", 200);
`ifdef ACQ_EARLY_EXIT_EN
        check("hit_clr_cnt", clr_cnt, 2);
        check("hit_busy_cyc", busy_cnt, 13);
`else
        check("hit_clr_cnt", clr_cnt, 4);
        check("hit_busy_cyc", busy_cnt, 25);
`endif
        check("hit_phs", bus.acq_prn_phs, 1);
        check("hit_peak", bus.corr_peak, 100);
        check("hit_ok", bus.acq_ok, 1);

        // abort in WAIT of phase 2, with a start pulse ignored while busy
        tab[0] = 10; tab[1] = 50; tab[2] = 50; tab[3] = 20;
        setup(3, 4, 200, 1);
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_state("abort_wait_to", 3, ST_WAIT);
        check("abort_at_phs", bus.prn_phs, 2);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        #1;
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_busy", bus.busy, 0);
        check("abort_ok", bus.acq_ok, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_peak", bus.corr_peak, 50);
        check("abort_phs", bus.acq_prn_phs, 1);

        // abort together with start in IDLE stays idle
        clr_cnt = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        #1;
        check("abst_busy", bus.busy, 0);
        check("abst_clr", clr_cnt, 0);
        check("abst_peak", bus.corr_peak, 50);

        // reset while dwelling on phase 5
        tab[4] = 30; tab[5] = 30; tab[6] = 30; tab[7] = 30;
        setup(7, 4, 1000, 1);
        pulse_start();
        wait_state("rst5_dwell_to", 6, ST_DWELL);
        check("rst5_at_phs", bus.prn_phs, 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst5_state", dbg_state, ST_IDLE);
        check("rst5_flags", {bus.acc_clr, bus.acc_en, bus.busy, bus.done, bus.acq_ok}, 0);
        check("rst5_prn_phs", bus.prn_phs, 0);
        check("rst5_acq_phs", bus.acq_prn_phs, 0);
        check("rst5_peak", bus.corr_peak, 0);

        samp_mode = 0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
